// File: rtl/coin_dispenser.sv
// Greedy coin payout controller for a 1-yuan / 5-jiao hopper pair with refillable inventories.
// Optional macro DISP_TIMEOUT_EN adds a hopper-ack timeout that aborts the payout with err.
module coin_dispenser #(
    parameter int unsigned INV_W   = 6,
    parameter int unsigned INIT_10 = 20,
    parameter int unsigned INIT_05 = 20,
    parameter int unsigned ACK_TMO = 15
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req,
    input  logic [3:0]       amount,
    input  logic             refill,
    input  logic [INV_W-1:0] refill_10,
    input  logic [INV_W-1:0] refill_05,
    input  logic             hop_ack,
    output logic             disp_10,
    output logic             disp_05,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [INV_W-1:0] inv10,
    output logic [INV_W-1:0] inv05
);

    localparam int unsigned CMP_W = INV_W + 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        FIRE10 = 3'd2,
        WAIT10 = 3'd3,
        FIRE05 = 3'd4,
        WAIT05 = 3'd5,
        FIN    = 3'd6,
        FAIL   = 3'd7
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       amt_q;
    logic [2:0]       rem10_q;
    logic [3:0]       rem05_q;
    logic [CMP_W-1:0] half_w_c;
    logic [CMP_W-1:0] inv10_w_c;
    logic [CMP_W-1:0] n10_w_c;
    logic [2:0]       n10_c;
    logic [3:0]       n05_c;
    logic             short05_c;
    logic [INV_W:0]   sum10_c;
    logic [INV_W:0]   sum05_c;
    logic             tmo_hit_c;

    // Greedy split: as many 1-yuan coins as inventory allows, remainder in 5-jiao coins.
    assign half_w_c  = CMP_W'(amt_q[3:1]);
    assign inv10_w_c = CMP_W'(inv10);
    assign n10_w_c   = (half_w_c <= inv10_w_c) ? half_w_c : inv10_w_c;
    assign n10_c     = 3'(n10_w_c);
    assign n05_c     = amt_q - {n10_c, 1'b0};
    assign short05_c = CMP_W'(n05_c) > CMP_W'(inv05);

    assign sum10_c = (INV_W+1)'(inv10) + (INV_W+1)'(refill_10);
    assign sum05_c = (INV_W+1)'(inv05) + (INV_W+1)'(refill_05);

`ifdef DISP_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(ACK_TMO + 1);

    // Counts cycles since the eject command; reloaded on every FIRE.
    logic [TMO_W-1:0] tmo_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_q <= '0;
        end else if (state_q == FIRE10 || state_q == FIRE05) begin
            tmo_q <= TMO_W'(1);
        end else if (state_q == WAIT10 || state_q == WAIT05) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end else begin
            tmo_q <= '0;
        end
    end

    assign tmo_hit_c = (tmo_q >= TMO_W'(ACK_TMO - 1));
`else
    assign tmo_hit_c = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) state_d = CHECK;
            end
            CHECK: begin
                if (amt_q == 4'd0)      state_d = FIN;
                else if (short05_c)     state_d = FAIL;
                else if (n10_c != 3'd0) state_d = FIRE10;
                else                    state_d = FIRE05;
            end
            FIRE10: state_d = WAIT10;
            WAIT10: begin
                if (hop_ack) begin
                    if (rem10_q != 3'd1)      state_d = FIRE10;
                    else if (rem05_q != 4'd0) state_d = FIRE05;
                    else                      state_d = FIN;
                end else if (tmo_hit_c) begin
                    state_d = FAIL;
                end
            end
            FIRE05: state_d = WAIT05;
            WAIT05: begin
                if (hop_ack) begin
                    if (rem05_q != 4'd1) state_d = FIRE05;
                    else                 state_d = FIN;
                end else if (tmo_hit_c) begin
                    state_d = FAIL;
                end
            end
            FIN:     state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, registered outputs and datapath.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            disp_10 <= 1'b0;
            disp_05 <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            inv10   <= INV_W'(INIT_10);
            inv05   <= INV_W'(INIT_05);
            amt_q   <= '0;
            rem10_q <= '0;
            rem05_q <= '0;
        end else begin
            state_q <= state_d;
            disp_10 <= (state_d == FIRE10);
            disp_05 <= (state_d == FIRE05);
            busy    <= (state_d != IDLE);
            done    <= (state_d == FIN);
            err     <= (state_d == FAIL);
            case (state_q)
                IDLE: begin
                    if (req) begin
                        amt_q <= amount;
                    end else if (refill) begin
                        inv10 <= sum10_c[INV_W] ? '1 : sum10_c[INV_W-1:0];
                        inv05 <= sum05_c[INV_W] ? '1 : sum05_c[INV_W-1:0];
                    end
                end
                CHECK: begin
                    rem10_q <= n10_c;
                    rem05_q <= n05_c;
                end
                WAIT10: begin
                    if (hop_ack) begin
                        inv10   <= inv10 - INV_W'(1);
                        rem10_q <= rem10_q - 3'd1;
                    end
                end
                WAIT05: begin
                    if (hop_ack) begin
                        inv05   <= inv05 - INV_W'(1);
                        rem05_q <= rem05_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
